// File: rtl/centroid_div_scheduler.sv
// Computes six per-frame centroids (total / count) with one shared restoring divider.
// The channels are processed in a fixed order, and all six results are committed together.
module centroid_div_scheduler #(
   parameter int WIDTH      = 25,
   parameter int MIN_PIXELS = 50,
   parameter int XW         = 11,
   parameter int YW         = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [6*WIDTH-1:0]   totals,
   input  logic [6*WIDTH-1:0]   counts,
   output logic [XW-1:0]        x_center_puck,
   output logic [XW-1:0]        x_center_paddle1,
   output logic [XW-1:0]        x_center_paddle2,
   output logic [YW-1:0]        y_center_puck,
   output logic [YW-1:0]        y_center_paddle1,
   output logic [YW-1:0]        y_center_paddle2,
   output logic                 frame_valid,
   output logic                 busy,
   output logic                 overrun
);

   // state  | meaning
   // IDLE   | waiting for start; the inputs are snapshotted on acceptance
   // LOAD   | select the operands of channel ch and clear the divider
   // DIVIDE | WIDTH cycles, one quotient bit per cycle, MSB first
   // STORE  | saturate the quotient into shadow[ch] and advance the channel
   // DONE   | commit all shadow values to the outputs at the closing edge
   typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, STORE, DONE} state_t;

   localparam int CW = $clog2(WIDTH);

   state_t              state, state_nx;
   logic [2:0]          ch;
   logic [CW-1:0]       bit_cnt;
   logic [6*WIDTH-1:0]  snap_tot, snap_cnt;
   logic [WIDTH-1:0]    dividend, divisor, quot;
   logic [WIDTH:0]      rem;
   logic [WIDTH-1:0]    cur_tot, cur_cnt;
   logic [WIDTH:0]      shifted, diff;
   logic                ge;
   logic [XW-1:0]       sat_q;
   logic [XW-1:0]       shadow [6];

   assign busy    = (state != IDLE);
   assign cur_tot = snap_tot[ch*WIDTH +: WIDTH];
   assign cur_cnt = snap_cnt[ch*WIDTH +: WIDTH];

   // The remainder stays below the divisor, so its top bit can be shifted out safely.
   assign shifted = {rem[WIDTH-1:0], dividend[WIDTH-1]};
   assign ge      = (shifted >= {1'b0, divisor});
   assign diff    = shifted - {1'b0, divisor};

   always_comb begin
      sat_q = '0;
      if (!ch[0])
         sat_q = (|quot[WIDTH-1:XW]) ? {XW{1'b1}} : quot[XW-1:0];
      else
         sat_q = (|quot[WIDTH-1:YW]) ? {{(XW-YW){1'b0}}, {YW{1'b1}}}
                                     : {{(XW-YW){1'b0}}, quot[YW-1:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    state_nx = DIVIDE;
         DIVIDE:  if (bit_cnt == '0) state_nx = STORE;
         STORE:   state_nx = (ch == 3'd5) ? DONE : LOAD;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_tot         <= '0;
         snap_cnt         <= '0;
         ch               <= '0;
         bit_cnt          <= '0;
         dividend         <= '0;
         divisor          <= '0;
         quot             <= '0;
         rem              <= '0;
         frame_valid      <= 1'b0;
         overrun          <= 1'b0;
         x_center_puck    <= '0;
         x_center_paddle1 <= '0;
         x_center_paddle2 <= '0;
         y_center_puck    <= '0;
         y_center_paddle1 <= '0;
         y_center_paddle2 <= '0;
         for (int i = 0; i < 6; i++) shadow[i] <= '0;
      end else begin
         frame_valid <= 1'b0;
         overrun     <= start && busy;
         case (state)
            IDLE: begin
               if (start) begin
                  snap_tot <= totals;
                  snap_cnt <= counts;
                  ch       <= '0;
               end
            end
            LOAD: begin
               dividend <= (cur_cnt > WIDTH'(MIN_PIXELS)) ? cur_tot : '0;
               divisor  <= (cur_cnt != '0) ? cur_cnt : WIDTH'(1);
               rem      <= '0;
               quot     <= '0;
               bit_cnt  <= CW'(WIDTH-1);
            end
            DIVIDE: begin
               rem      <= ge ? diff : shifted;
               quot     <= {quot[WIDTH-2:0], ge};
               dividend <= dividend << 1;
               bit_cnt  <= bit_cnt - 1'b1;
            end
            STORE: begin
               shadow[ch] <= sat_q;
               if (ch != 3'd5) ch <= ch + 3'd1;
            end
            DONE: begin
               x_center_puck    <= shadow[0];
               y_center_puck    <= shadow[1][YW-1:0];
               x_center_paddle1 <= shadow[2];
               y_center_paddle1 <= shadow[3][YW-1:0];
               x_center_paddle2 <= shadow[4];
               y_center_paddle2 <= shadow[5][YW-1:0];
               frame_valid      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// Self-checking bench for centroid_div_scheduler, using directed frame vectors
// and sequences for overrun, mid-frame reset and input isolation.
module tb_centroid_div_scheduler;

   localparam int W   = 25;
   localparam int TW  = 6*W;
   localparam int LAT = 163;

   logic           clk = 1'b0;
   logic           reset, start;
   logic [TW-1:0]  totals, counts;
   logic [10:0]    x_center_puck, x_center_paddle1, x_center_paddle2;
   logic [9:0]     y_center_puck, y_center_paddle1, y_center_paddle2;
   logic           frame_valid, busy, overrun;

   centroid_div_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .totals(totals), .counts(counts),
      .x_center_puck(x_center_puck), .x_center_paddle1(x_center_paddle1),
      .x_center_paddle2(x_center_paddle2), .y_center_puck(y_center_puck),
      .y_center_paddle1(y_center_paddle1), .y_center_paddle2(y_center_paddle2),
      .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tot;
      logic [TW-1:0] cnt;
      logic [65:0]   ex;
   } vec_t;

   vec_t vec [5];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   prev_v [6];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int get_out(input int k);
      case (k)
         0: return int'(x_center_puck);
         1: return int'(y_center_puck);
         2: return int'(x_center_paddle1);
         3: return int'(y_center_paddle1);
         4: return int'(x_center_paddle2);
         default: return int'(y_center_paddle2);
      endcase
   endfunction

   task automatic set_ch(input int i, input int k, input int t, input int c, input int e);
      vec[i].tot[k*W +: W] = W'(t);
      vec[i].cnt[k*W +: W] = W'(c);
      vec[i].ex[k*11 +: 11] = 11'(e);
   endtask

   // ovr_at: cycle of a second start (0 = none); scramble: randomize inputs while busy
   task automatic run_frame(input int vi, input int ovr_at, input bit scramble, input bit post_chk);
      int  cycles;
      bit  got, stable_bad;
      cycles = 0; got = 0; stable_bad = 0;
      totals = vec[vi].tot;
      counts = vec[vi].cnt;
      start  = 1'b1;
      @(posedge clk);
      while (!got && cycles < 400) begin
         @(negedge clk);
         if (frame_valid) got = 1;
         else begin
            start = (ovr_at != 0 && cycles == ovr_at);
            if (scramble) begin
               totals = TW'({$urandom, $urandom, $urandom, $urandom, $urandom});
               counts = TW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            end
            if (ovr_at != 0 && cycles == ovr_at + 1) check("overrun_pulse", int'(overrun), 1);
            if (ovr_at != 0 && cycles == ovr_at + 2) check("overrun_clear", int'(overrun), 0);
            for (int k = 0; k < 6; k++) if (get_out(k) != prev_v[k]) stable_bad = 1;
            @(posedge clk);
            cycles++;
         end
      end
      start = 1'b0;
      check($sformatf("v%0d_latency", vi), cycles, LAT);
      check($sformatf("v%0d_stable", vi), int'(stable_bad), 0);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("v%0d_ch%0d", vi, k), get_out(k), int'(vec[vi].ex[k*11 +: 11]));
         prev_v[k] = int'(vec[vi].ex[k*11 +: 11]);
      end
      if (post_chk) begin
         @(negedge clk);
         check($sformatf("v%0d_fv_single", vi), int'(frame_valid), 0);
         check($sformatf("v%0d_busy_after", vi), int'(busy), 0);
      end
   endtask

   initial begin
      int fv_seen;
      for (int i = 0; i < 5; i++) begin
         vec[i].tot = '0; vec[i].cnt = '0; vec[i].ex = '0;
      end
      for (int k = 0; k < 6; k++) prev_v[k] = 0;
      set_ch(0, 0, 32000, 100, 320);          set_ch(0, 1, 24000, 100, 240);
      set_ch(1, 0, 640000, 1000, 640);        set_ch(1, 1, 1000, 50, 0);
      set_ch(1, 2, 15000, 50, 0);             set_ch(1, 3, 5000, 0, 0);
      set_ch(1, 4, 1001, 100, 10);            set_ch(1, 5, 102000, 51, 1023);
      set_ch(2, 0, 122820, 60, 2047);         set_ch(2, 1, 61440, 60, 1023);
      set_ch(2, 2, 15300, 51, 300);           set_ch(2, 3, 999, 1000, 0);
      set_ch(2, 4, 153000, 51, 2047);         set_ch(2, 5, 52173, 51, 1023);
      set_ch(3, 0, 33554431, 33554431, 1);    set_ch(3, 1, 33554431, 51, 1023);
      set_ch(3, 2, 100, 51, 1);               set_ch(3, 3, 33554431, 65536, 511);
      set_ch(3, 4, 50, 51, 0);                set_ch(3, 5, 1000, 1, 0);
      set_ch(4, 0, 32000, 100, 320);          set_ch(4, 1, 24000, 100, 240);
      set_ch(4, 2, 15300, 51, 300);           set_ch(4, 3, 10000, 100, 100);
      set_ch(4, 4, 1001, 100, 10);            set_ch(4, 5, 102000, 51, 1023);

      reset = 1'b1; start = 1'b0; totals = '0; counts = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) check($sformatf("rst_ch%0d", k), get_out(k), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_fv", int'(frame_valid), 0);
      check("rst_overrun", int'(overrun), 0);

      for (int i = 0; i < 5; i++) run_frame(i, 0, 1'b0, 1'b1);

      // second start while busy is ignored; the next start follows the DONE cycle at once
      run_frame(0, 40, 1'b1, 1'b0);
      run_frame(2, 0, 1'b1, 1'b1);

      // start coincident with reset must not be accepted
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("rst_start_busy", int'(busy), 0);
      for (int k = 0; k < 6; k++) prev_v[k] = 0;

      run_frame(4, 0, 1'b0, 1'b1);

      // abort a frame with reset at cycle 80
      totals = vec[1].tot; counts = vec[1].cnt; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (79) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) check($sformatf("abort_ch%0d", k), get_out(k), 0);
      check("abort_busy", int'(busy), 0);
      fv_seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (frame_valid) fv_seen++;
      end
      check("abort_no_fv", fv_seen, 0);
      for (int k = 0; k < 6; k++) prev_v[k] = 0;

      run_frame(4, 0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
